// File: rtl/bldc_pid_driver.sv
// Period-synchronous PID loop driving hall-commutated six-step BLDC gates.
// Optional DEADTIME_EN blanks PHASES for DEADTIME cycles on every pattern change.
module bldc_pid_driver #(
   parameter int PWM_BITS    = 9,
   parameter int DATA_W      = 24,
   parameter int ACC_W       = 32,
   parameter int KD_DIV_BITS = 3,
   parameter int DEADTIME    = 4
) (
   input  logic                CLK,
   input  logic                reset,
   input  logic                enable,
   input  logic [2:0]          hall,
   input  logic [DATA_W-1:0]   setpoint,
   input  logic [DATA_W-1:0]   state,
   input  logic [DATA_W-1:0]   Kp,
   input  logic [DATA_W-1:0]   Ki,
   input  logic [DATA_W-1:0]   Kd,
   input  logic [DATA_W-1:0]   IntegralLimit,
   input  logic [PWM_BITS:0]   PWMLimit,
   input  logic [PWM_BITS:0]   deadband,
   output logic [PWM_BITS:0]   pwm,
   output logic [5:0]          PHASES,
   output logic                hall_fault,
   output logic                pid_tick
);

   localparam int LW  = PWM_BITS + 1;
   localparam int AW1 = ACC_W + 1;
   localparam int PW  = DATA_W + ACC_W;
   localparam int DW  = DATA_W + ACC_W + 1;
   localparam int SW  = ACC_W + DATA_W + 2;
   localparam int MAXD = (1 << PWM_BITS) - 1;
   localparam logic signed [LW-1:0] MAX_DUTY = LW'(MAXD);

   logic [PWM_BITS-1:0]      cnt_q, cnt_d;
   logic [3:1]               v_q, v_d;
   logic                     run_q, run_d;
   logic signed [ACC_W-1:0]  err_q, err_d, integ_q, integ_d, err_ref_q, err_ref_d;
   logic [KD_DIV_BITS-1:0]   kd_cnt_q, kd_cnt_d;
   logic signed [PW-1:0]     p_q, p_d, i_prod;
   logic signed [DW-1:0]     d_q, d_d;
   logic signed [SW-1:0]     sum_q, sum_d, db, lim_s;
   logic signed [LW-1:0]     pwm_q, pwm_d, duty_q, duty_d, duty_now, lim_eff;
   logic signed [AW1-1:0]    isum, ilim, ediff;
   logic [LW-1:0]            mag;
   logic [5:0]               ph_q, ph_d, pat, tgt;
   logic                     fault_q, fault_d, tick_q, tick_d;
   logic                     period_start, active, conduct, fwd;

   // PID pipeline: launch at count 0, result lands at T+4.
   always_comb begin
      period_start = (cnt_q == '0);
      cnt_d        = cnt_q + 1'b1;
      v_d          = {v_q[2:1], period_start};
      run_d        = enable & (period_start | run_q);
      active       = enable & run_q;
      err_d        = err_q;
      integ_d      = integ_q;
      err_ref_d    = err_ref_q;
      kd_cnt_d     = kd_cnt_q;
      p_d          = p_q;
      d_d          = d_q;
      sum_d        = sum_q;
      pwm_d        = pwm_q;
      tick_d       = v_q[3];
      isum         = AW1'(integ_q) + AW1'(err_q);
      ilim         = AW1'($signed(IntegralLimit));
      ediff        = AW1'(err_q) - AW1'(err_ref_q);
      i_prod       = PW'($signed(Ki)) * PW'(integ_q);
      db           = SW'($signed(deadband));
      lim_eff      = $signed(PWMLimit);
      if (lim_eff[LW-1])
         lim_eff = '0;
      else if (lim_eff > MAX_DUTY)
         lim_eff = MAX_DUTY;
      lim_s = SW'(lim_eff);

      if (period_start)
         err_d = ACC_W'($signed(state)) - ACC_W'($signed(setpoint));
      if (v_q[1]) begin
         p_d      = PW'($signed(Kp)) * PW'(err_q);
         d_d      = DW'($signed(Kd)) * DW'(ediff);
         kd_cnt_d = kd_cnt_q + 1'b1;
         if (kd_cnt_q == '0)
            err_ref_d = err_q;
         if (isum > ilim)
            integ_d = ACC_W'(ilim);
         else if (isum < -ilim)
            integ_d = ACC_W'(-ilim);
         else
            integ_d = ACC_W'(isum);
      end
      if (v_q[2])
         sum_d = SW'(p_q) + SW'(i_prod) + SW'(d_q);
      if (v_q[3]) begin
         if ((sum_q <= db) && (sum_q >= -db))
            pwm_d = '0;
         else if (sum_q > lim_s)
            pwm_d = lim_eff;
         else if (sum_q < -lim_s)
            pwm_d = -lim_eff;
         else
            pwm_d = LW'(sum_q);
      end
      if (!active) begin
         integ_d = '0;
         pwm_d   = '0;
      end
   end

   // Duty seen at count 0 is the freshly latched value, so a period never mixes two duties.
   always_comb begin
      duty_now = enable ? ((cnt_q == '0) ? pwm_q : duty_q) : '0;
      duty_d   = duty_now;
      mag      = duty_now[LW-1] ? LW'(-duty_now) : LW'(duty_now);
      conduct  = ({1'b0, cnt_q} < mag);
      fwd      = ~duty_now[LW-1];
      fault_d  = fault_q | (hall == 3'b000) | (hall == 3'b111);
      case (hall)
         3'b101:  pat = fwd ? 6'b100100 : 6'b011000;
         3'b100:  pat = fwd ? 6'b100001 : 6'b010010;
         3'b110:  pat = fwd ? 6'b001001 : 6'b000110;
         3'b010:  pat = fwd ? 6'b011000 : 6'b100100;
         3'b011:  pat = fwd ? 6'b010010 : 6'b100001;
         3'b001:  pat = fwd ? 6'b000110 : 6'b001001;
         default: pat = 6'b000000;
      endcase
      tgt = (enable && conduct) ? pat : 6'b000000;
   end

`ifdef DEADTIME_EN
   localparam int DT_W = $clog2(DEADTIME + 2);
   logic [DT_W-1:0] dt_q, dt_d;
   logic [5:0]      prev_q;

   always_comb begin
      ph_d = tgt;
      dt_d = dt_q;
      if (tgt == 6'b000000) begin
         dt_d = '0;
      end else if (tgt != prev_q) begin
         if (DEADTIME > 0) begin
            ph_d = 6'b000000;
            dt_d = DT_W'(DEADTIME - 1);
         end
      end else if (dt_q != '0) begin
         ph_d = 6'b000000;
         dt_d = dt_q - 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         dt_q   <= '0;
         prev_q <= '0;
      end else begin
         dt_q   <= dt_d;
         prev_q <= tgt;
      end
   end
`else
   always_comb ph_d = tgt;
`endif

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         cnt_q     <= '0;
         v_q       <= '0;
         run_q     <= 1'b0;
         err_q     <= '0;
         integ_q   <= '0;
         err_ref_q <= '0;
         kd_cnt_q  <= '0;
         p_q       <= '0;
         d_q       <= '0;
         sum_q     <= '0;
         pwm_q     <= '0;
         duty_q    <= '0;
         ph_q      <= '0;
         fault_q   <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         v_q       <= v_d;
         run_q     <= run_d;
         err_q     <= err_d;
         integ_q   <= integ_d;
         err_ref_q <= err_ref_d;
         kd_cnt_q  <= kd_cnt_d;
         p_q       <= p_d;
         d_q       <= d_d;
         sum_q     <= sum_d;
         pwm_q     <= pwm_d;
         duty_q    <= duty_d;
         ph_q      <= ph_d;
         fault_q   <= fault_d;
         tick_q    <= tick_d;
      end
   end

   assign pwm        = pwm_q;
   assign PHASES     = ph_q;
   assign hall_fault = fault_q;
   assign pid_tick   = tick_q;

endmodule
